mc_decoder: RTL

Multicycle control decoder for the ARM-subset CPU. It sequences every instruction through a Moore main FSM and decodes ALU operation, flag-write enables, immediate and register-source selects from the latched instruction fields. It sits directly upstream of the conditional-execution logic: its `PCS`, `RegW`, `MemW`, `FlagW` and `NoWrite` feed that block, which gates them with the condition check. All other outputs drive the multicycle datapath muxes and enables.

---
 rtl/cpu_ctrl_pkg.sv | 41 ++++
 rtl/main_fsm.sv | 105 ++++++++++
 rtl/mc_decoder.sv | 101 ++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the multicycle ARM-subset CPU.
// Holds the main FSM state enum, datapath mux select codes and Op codes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        UNKNOWN
    } statetype;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UNK = 2'b11;

endpackage

// File: rtl/main_fsm.sv
// Moore main FSM: state register, next-state logic and per-state outputs.
// Ports: clk, reset, Op, FunctI (Funct[5]), FunctL (Funct[0]) in; mux selects and strobes out.
module main_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic       FunctI,
    input  logic       FunctL,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ALUOp,
    output logic       Branch
);

    statetype state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        unique case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                unique case (Op)
                    OP_MEM:  state_d = MEMADR;
                    OP_DP:   state_d = FunctI ? EXECI : EXECR;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = UNKNOWN;
                endcase
            end
            MEMADR:  state_d = FunctL ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = FETCH;
            EXECR:   state_d = ALUWB;
            EXECI:   state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            UNKNOWN: state_d = UNKNOWN;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_RD2;
        ALUOp     = 1'b0;
        Branch    = 1'b0;
        unique case (state_q)
            FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR: ALUSrcB = SRCB_EXTIMM;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECR: ALUOp = 1'b1;
            EXECI: begin
                ALUSrcB = SRCB_EXTIMM;
                ALUOp   = 1'b1;
            end
            ALUWB: RegW = 1'b1;
            BRANCH: begin
                ALUSrcA   = SRCA_ALUOUT;
                ALUSrcB   = SRCB_EXTIMM;
                ResultSrc = RES_ALURESULT;
                Branch    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_decoder.sv
// Multicycle control decoder: main FSM plus ALU decode, PC logic and instruction decode.
// Ports: clk, reset, Op, Funct, Rd in; FlagW, PCS, NextPC, RegW, MemW, NoWrite, mux selects out.
module mc_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       NoWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc
);

    logic       irw_raw, npc_raw, regw_raw, memw_raw;
    logic       alu_op, branch;
    logic       cmd_ok, cmd_cv;
    logic [3:0] cmd;

    main_fsm u_fsm (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .FunctI   (Funct[5]),
        .FunctL   (Funct[0]),
        .IRWrite  (irw_raw),
        .NextPC   (npc_raw),
        .RegW     (regw_raw),
        .MemW     (memw_raw),
        .AdrSrc   (AdrSrc),
        .ResultSrc(ResultSrc),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (alu_op),
        .Branch   (branch)
    );

    assign cmd = Funct[4:1];

    // cmd_cv marks arithmetic ops that also own the carry/overflow flags.
    always_comb begin
        ALUControl = ALU_ADD;
        NoWrite    = 1'b0;
        cmd_ok     = 1'b0;
        cmd_cv     = 1'b0;
        if (alu_op) begin
            unique case (cmd)
                4'b0100: begin
                    ALUControl = ALU_ADD;
                    cmd_ok = 1'b1;
                    cmd_cv = 1'b1;
                end
                4'b0010: begin
                    ALUControl = ALU_SUB;
                    cmd_ok = 1'b1;
                    cmd_cv = 1'b1;
                end
                4'b0000: begin
                    ALUControl = ALU_AND;
                    cmd_ok = 1'b1;
                end
                4'b1100: begin
                    ALUControl = ALU_ORR;
                    cmd_ok = 1'b1;
                end
                4'b1010: begin
                    ALUControl = ALU_SUB;
                    NoWrite = 1'b1;
                    cmd_ok = 1'b1;
                    cmd_cv = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Strobes are held low while reset so an aborted instruction writes nothing.
    assign FlagW   = reset ? 2'b00
                   : {cmd_ok & Funct[0], cmd_ok & cmd_cv & Funct[0]};
    assign IRWrite = irw_raw  & ~reset;
    assign NextPC  = npc_raw  & ~reset;
    assign RegW    = regw_raw & ~reset;
    assign MemW    = memw_raw & ~reset;
    assign PCS     = ~reset & ((regw_raw & (Rd == 4'hF)) | branch);

    assign ImmSrc  = Op;
    assign RegSrc  = {Op == OP_MEM, Op == OP_BR};

endmodule
